// File: rtl/shared_mem_responder.sv
// Memory-side responder: accepts serialized word requests, writes an internal RAM
// and returns read data through a request stage (A) and a response stage (B).
module shared_mem_responder #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH_LOG = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              wren,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [DATA_W-1:0] data_to_mem,
    output logic              req_ready,
    output logic [DATA_W-1:0] data_from_mem,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              wr_ack,
    output logic              err,
    input  logic              err_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

    // Addresses with any bit set above the RAM index are flagged, never aliased.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return (a[ADDR_W-1:DEPTH_LOG] == {(ADDR_W-DEPTH_LOG){1'b0}});
    endfunction

    stage_e              a_state_q, a_state_d;
    logic                a_we_q, a_we_d;
    logic [ADDR_W-1:0]   a_addr_q, a_addr_d;
    logic [DATA_W-1:0]   a_data_q, a_data_d;
    stage_e              b_state_q, b_state_d;
    logic [DATA_W-1:0]   b_data_q, b_data_d;
    logic                wr_ack_q, wr_ack_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem_q [0:DEPTH-1];

    logic                a_full_s;
    logic                b_full_s;
    logic                a_adv_s;
    logic                accept_s;
    logic                a_in_range_s;
    logic [DEPTH_LOG-1:0] a_idx_s;
    logic [DATA_W-1:0]   rd_data_s;
    logic                mem_we_s;

    // Handshake: writes always drain A; reads wait only on a stalled B.
    always_comb begin
        a_full_s     = (a_state_q == ST_FULL);
        b_full_s     = (b_state_q == ST_FULL);
        a_adv_s      = a_full_s && (a_we_q || !b_full_s || rsp_ready);
        accept_s     = req && (!a_full_s || a_adv_s);
        a_in_range_s = addr_in_range(a_addr_q);
        a_idx_s      = a_addr_q[DEPTH_LOG-1:0];
        mem_we_s     = a_adv_s && a_we_q && a_in_range_s;
        if (a_in_range_s) begin
            rd_data_s = mem_q[a_idx_s];
        end else begin
            rd_data_s = {DATA_W{1'b0}};
        end
    end

    // Next-state for both pipeline stages, write acknowledge and sticky error.
    always_comb begin
        a_state_d = a_state_q;
        a_we_d    = a_we_q;
        a_addr_d  = a_addr_q;
        a_data_d  = a_data_q;
        b_state_d = b_state_q;
        b_data_d  = b_data_q;
        wr_ack_d  = a_adv_s && a_we_q;
        err_d     = err_q;

        if (accept_s) begin
            a_state_d = ST_FULL;
            a_we_d    = wren;
            a_addr_d  = addr_mem;
            a_data_d  = data_to_mem;
        end else if (a_adv_s) begin
            a_state_d = ST_EMPTY;
        end else begin
            a_state_d = a_state_q;
        end

        // A new read entering B wins over a same-edge consume, so no bubble.
        if (a_adv_s && !a_we_q) begin
            b_state_d = ST_FULL;
            b_data_d  = rd_data_s;
        end else if (b_full_s && rsp_ready) begin
            b_state_d = ST_EMPTY;
        end else begin
            b_state_d = b_state_q;
        end

        if (a_adv_s && !a_in_range_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Pipeline and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_state_q <= ST_EMPTY;
            a_we_q    <= 1'b0;
            a_addr_q  <= {ADDR_W{1'b0}};
            a_data_q  <= {DATA_W{1'b0}};
            b_state_q <= ST_EMPTY;
            b_data_q  <= {DATA_W{1'b0}};
            wr_ack_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            a_state_q <= a_state_d;
            a_we_q    <= a_we_d;
            a_addr_q  <= a_addr_d;
            a_data_q  <= a_data_d;
            b_state_q <= b_state_d;
            b_data_q  <= b_data_d;
            wr_ack_q  <= wr_ack_d;
            err_q     <= err_d;
        end
    end

    // RAM array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[a_idx_s] <= a_data_q;
        end
    end

    assign req_ready     = !a_full_s || a_adv_s;
    assign rsp_valid     = b_full_s;
    assign data_from_mem = b_data_q;
    assign wr_ack        = wr_ack_q;
    assign err           = err_q;

endmodule

// File: tb/tb_shared_mem_responder.sv
// Directed and randomized checks of shared_mem_responder against a
// word-array reference model with an in-order expected-response queue.
module tb_shared_mem_responder;

    logic        clk;
    logic        reset_n;
    logic        req;
    logic        wren;
    logic [15:0] addr_mem;
    logic [15:0] data_to_mem;
    logic        req_ready;
    logic [15:0] data_from_mem;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        wr_ack;
    logic        err;
    logic        err_clr;

    int checks    = 0;
    int failures  = 0;
    int writes    = 0;
    int acks      = 0;
    int rsp_count = 0;

    logic [15:0] model_mem [0:1023];
    logic [15:0] exp_q [$];

    shared_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG(10)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .wren         (wren),
        .addr_mem     (addr_mem),
        .data_to_mem  (data_to_mem),
        .req_ready    (req_ready),
        .data_from_mem(data_from_mem),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .wr_ack       (wr_ack),
        .err          (err),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One controller cycle: drive, settle, score accept/consume, clock.
    task automatic cycle_drive(input logic r, input logic we, input logic [15:0] a,
                               input logic [15:0] d, input logic rr,
                               output logic acc, output logic rdy);
        logic [15:0] e;
        req = r; wren = we; addr_mem = a; data_to_mem = d; rsp_ready = rr;
        #1;
        rdy = req_ready;
        acc = r && req_ready;
        if (rsp_valid && rr) begin
            chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_data", 32'(data_from_mem), 32'(e));
            end
            rsp_count++;
        end
        if (acc) begin
            if (we) begin
                writes++;
                if (a < 16'd1024) model_mem[a[9:0]] = d;
            end else begin
                exp_q.push_back((a < 16'd1024) ? model_mem[a[9:0]] : 16'h0000);
            end
        end
        @(posedge clk);
        #1;
        if (wr_ack) acks++;
    endtask

    initial begin
        logic        acc;
        logic        rdy;
        logic        rr;
        logic        seen;
        logic        saw_nr;
        logic        hold_we;
        logic [15:0] hold_a;
        logic [15:0] hold_d;
        int          idx;
        int          stall;
        int          guard;
        int          n;
        int          rsp_base;

        reset_n = 1'b0; req = 1'b0; wren = 1'b0; addr_mem = 16'h0000;
        data_to_mem = 16'h0000; rsp_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data", 32'(data_from_mem), 32'd0);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        reset_n = 1'b1;

        // Back-to-back write then read of the same address.
        cycle_drive(1'b1, 1'b1, 16'h0005, 16'hBEEF, 1'b1, acc, rdy);
        chk("wb_wr_acc", 32'(acc), 32'd1);
        cycle_drive(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, acc, rdy);
        chk("wb_rd_acc", 32'(acc), 32'd1);
        chk("wb_wr_ack", 32'(wr_ack), 32'd1);
        chk("wb_no_rsp_yet", 32'(rsp_valid), 32'd0);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        chk("wb_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wb_rsp_data", 32'(data_from_mem), 32'h0000BEEF);
        chk("wb_ack_pulse", 32'(wr_ack), 32'd0);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        chk("wb_consumed", 32'(rsp_valid), 32'd0);

        // Preload 0..3 with 0x1000..0x1003.
        for (int i = 0; i < 4; i++)
            cycle_drive(1'b1, 1'b1, 16'(i), 16'h1000 + 16'(i), 1'b1, acc, rdy);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);

        // Streaming reads with three stall cycles after the first response.
        idx = 0; seen = 1'b0; stall = 0; saw_nr = 1'b0; guard = 0;
        rsp_base = rsp_count;
        while ((idx < 4 || exp_q.size() != 0) && guard < 40) begin
            if (rsp_valid && !seen) begin
                seen = 1'b1;
                stall = 3;
            end
            if (stall > 0) begin
                chk("bp_stall_data", 32'(data_from_mem), 32'h00001000);
                chk("bp_stall_valid", 32'(rsp_valid), 32'd1);
                rr = 1'b0;
                stall--;
            end else begin
                rr = 1'b1;
            end
            cycle_drive(idx < 4, 1'b0, 16'(idx), 16'h0000, rr, acc, rdy);
            if (!rdy) saw_nr = 1'b1;
            if (acc) idx++;
            guard++;
        end
        chk("bp_all_issued", 32'(idx), 32'd4);
        chk("bp_req_ready_dropped", 32'(saw_nr), 32'd1);
        chk("bp_rsp_count", 32'(rsp_count - rsp_base), 32'd4);

        // Write bypasses a stalled B.
        cycle_drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, acc, rdy);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, acc, rdy);
        chk("byp_b_full", 32'(rsp_valid), 32'd1);
        cycle_drive(1'b1, 1'b1, 16'h0007, 16'h00AA, 1'b0, acc, rdy);
        chk("byp_wr_acc", 32'(acc), 32'd1);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, acc, rdy);
        chk("byp_wr_ack", 32'(wr_ack), 32'd1);
        chk("byp_b_held", 32'(data_from_mem), 32'h00001000);
        cycle_drive(1'b1, 1'b0, 16'h0007, 16'h0000, 1'b1, acc, rdy);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        chk("byp_rd7_data", 32'(data_from_mem), 32'h000000AA);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);

        // Out-of-range write, then read back address 0 and an out-of-range read.
        chk("oor_err_before", 32'(err), 32'd0);
        cycle_drive(1'b1, 1'b1, 16'h0400, 16'h1234, 1'b1, acc, rdy);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        chk("oor_wr_ack", 32'(wr_ack), 32'd1);
        chk("oor_err_set", 32'(err), 32'd1);
        cycle_drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        chk("oor_ram0_kept", 32'(data_from_mem), 32'h00001000);
        cycle_drive(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, acc, rdy);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        chk("oor_rd_zero", 32'(data_from_mem), 32'h00000000);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        chk("oor_err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        err_clr = 1'b0;
        chk("oor_err_clr", 32'(err), 32'd0);
        cycle_drive(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, acc, rdy);
        err_clr = 1'b1;
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        err_clr = 1'b0;
        chk("oor_set_beats_clr", 32'(err), 32'd1);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);

        // Reset mid-operation with a read in B and an uncommitted write in A.
        cycle_drive(1'b1, 1'b1, 16'h0009, 16'h1111, 1'b1, acc, rdy);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        cycle_drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, acc, rdy);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, acc, rdy);
        chk("mrst_b_full", 32'(rsp_valid), 32'd1);
        cycle_drive(1'b1, 1'b1, 16'h0009, 16'h2222, 1'b0, acc, rdy);
        chk("mrst_wr_acc", 32'(acc), 32'd1);
        req = 1'b0; wren = 1'b0; reset_n = 1'b0;
        #1;
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_data", 32'(data_from_mem), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        chk("mrst_req_ready", 32'(req_ready), 32'd1);
        model_mem[9] = 16'h1111;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("mrst_no_ack", 32'(wr_ack), 32'd0);
        reset_n = 1'b1;
        cycle_drive(1'b1, 1'b0, 16'h0009, 16'h0000, 1'b1, acc, rdy);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        chk("mrst_write_lost", 32'(data_from_mem), 32'h00001111);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);

        // Randomized mixed traffic against the reference model.
        for (int i = 0; i < 32; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 4 && !acc; t++)
                cycle_drive(1'b1, 1'b1, 16'(i), 16'($urandom), 1'b1, acc, rdy);
        end
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        writes = 0; acks = 0;
        n = 0; guard = 0;
        hold_we = 1'($urandom); hold_d = 16'($urandom);
        hold_a = ($urandom_range(0, 7) == 0) ? (16'($urandom) | 16'h0400) : 16'($urandom_range(0, 31));
        while (n < 256 && guard < 5000) begin
            rr = ($urandom_range(0, 3) != 0);
            cycle_drive(1'b1, hold_we, hold_a, hold_d, rr, acc, rdy);
            if (acc) begin
                n++;
                hold_we = 1'($urandom); hold_d = 16'($urandom);
                hold_a = ($urandom_range(0, 7) == 0) ? (16'($urandom) | 16'h0400) : 16'($urandom_range(0, 31));
            end
            guard++;
        end
        chk("rand_issued", 32'(n), 32'd256);
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
            guard++;
        end
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        cycle_drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc, rdy);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_ack_count", 32'(acks), 32'(writes));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
